riscv_lsu: RTL
==============

Name: riscv_lsu

Overview:
Load/store execution unit that consumes the decode-stage `lsu_opt`/`funct3` controls together with the ALU address result. It sits between EX and WB and runs one memory transaction at a time on a simple valid/ready request / valid response memory port. Loads are returned sign- or zero-extended; stores are byte-lane aligned with write strobes. NONE/SYS operations pass the ALU result through so the stage is uniform.

Parameters:
DATA_WIDTH, 32, data and address width (RV32; the alignment logic below is defined for 32 only)
STRB_WIDTH, DATA_WIDTH/8, number of write-strobe bits

Ports:
clk  input  1  clock; all logic is rising-edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  EX presents an instruction
in_ready  output  1  LSU can accept; high only in IDLE
in_lsu_opt  input  `LSU_OPT_WIDTH  LSU_OPT_NONE / LOAD / STORE / SYS (riscv_define.v encodings)
in_funct3  input  3  access size and sign
in_addr  input  DATA_WIDTH  ALU result (effective address or pass-through value)
in_wdata  input  DATA_WIDTH  rs2 value for stores
mem_req_valid  output  1  request valid
mem_req_ready  input  1  memory accepts the request
mem_req_we  output  1  1 = write
mem_req_addr  output  DATA_WIDTH  word address {addr[31:2],2'b00}
mem_req_wdata  output  DATA_WIDTH  lane-shifted store data
mem_req_wstrb  output  STRB_WIDTH  byte enables; 0 for reads
mem_resp_valid  input  1  response / write acknowledge, one-cycle pulse
mem_resp_rdata  input  DATA_WIDTH  read word
mem_resp_err  input  1  bus error, qualified by mem_resp_valid
out_valid  output  1  result valid to WB
out_ready  input  1  WB accepts
out_data  output  DATA_WIDTH  formatted load data, or pass-through in_addr; 0 for stores
out_wen  output  1  1 for LOAD and NONE, 0 for STORE and SYS; forced 0 whenever out_misalign or out_err is 1
out_misalign  output  1  misaligned access; no bus transaction was issued
out_err  output  1  bus error, or an illegal funct3 for LOAD/STORE

Behaviour:
- Reset, asynchronous, `rst_n` = 0: state goes to IDLE. All outputs are 0 except `in_ready` = 1. All latches clear. Reset in the middle of a transaction drops `mem_req_valid` immediately, and any late `mem_resp_valid` in IDLE is ignored.
- FSM states are IDLE, REQ, WAIT and DONE.
- IDLE: `in_ready` = 1. On `in_valid` the LSU latches opt, funct3, addr and wdata.
  - If opt is LOAD or STORE, the access is legal and aligned, the next state is REQ.
  - Any other case goes to DONE: NONE/SYS pass-through, misaligned access, or illegal funct3.
- Legal funct3 values:
  - LOAD: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - STORE: 000 sb, 001 sh, 010 sw.
  - Any other value sets `out_err` = 1.
- Misalignment: a halfword access with addr[0] = 1, or a word access with addr[1:0] ≠ 0, sets `out_misalign` = 1.
- REQ: `mem_req_valid` = 1. `mem_req_*` are driven from the latches and stay stable until `mem_req_ready`, then the next state is WAIT. A `mem_resp_valid` seen in REQ is ignored (protocol violation).
- WAIT: on `mem_resp_valid` the LSU captures the formatted data and `mem_resp_err`, then goes to DONE. There is no timeout.
- DONE: `out_valid` = 1 and all `out_*` hold until `out_ready`, then the next state is IDLE. No new instruction is accepted in the same cycle.
- Minimum latency from acceptance to `out_valid`:
  - memory op with `mem_req_ready` = 1 and a response one cycle later: 3 cycles;
  - pass-through or trap: 1 cycle.
- Store formatting, with o = addr[1:0]:
  - sb: wdata = {4{wdata[7:0]}}, wstrb = 4'b0001 << o.
  - sh: wdata = {2{wdata[15:0]}}, wstrb = 4'b0011 << {o[1],1'b0}.
  - sw: wdata unchanged, wstrb = 4'b1111.
- Load formatting: the byte is selected by addr[1:0] and the halfword by addr[1].
  - lb/lh sign-extend.
  - lbu/lhu zero-extend.
  - lw passes the word through.
- Bus error: `out_err` = 1, `out_data` = 0 and `out_wen` = 0.

Test Plan:
- lw at addr 0x80000004, `mem_req_ready` = 1, response 0xDEADBEEF one cycle after acceptance -> `mem_req_addr` = 0x80000004, `wstrb` = 0; `out_valid` 3 cycles after acceptance with `out_data` = 0xDEADBEEF, `out_wen` = 1.
- lb at addr 0x80000003 with response 0x80FF7F01 -> `out_data` = 0xFFFFFF80; lbu at the same address -> 0x00000080; lh at 0x80000002 -> 0xFFFF80FF.
- sb at addr 0x80000002 with wdata 0x12345678 -> `mem_req_we` = 1, `wdata` = 0x78787878, `wstrb` = 0b0100; sh at 0x80000002 -> `wdata` = 0x56785678, `wstrb` = 0b1100; `out_wen` = 0.
- `mem_req_ready` held low for 5 cycles, then `out_ready` held low for 3 cycles -> request signals and `out_*` stay stable throughout; `in_ready` = 0 until the DONE handshake completes.
- lw at 0x80000002 -> no `mem_req_valid`, `out_valid` next cycle with `out_misalign` = 1, `out_wen` = 0. LOAD with funct3 = 011 -> `out_err` = 1. NONE with addr 0x1234 -> `out_data` = 0x1234, `out_wen` = 1, latency 1.
- `rst_n` asserted while in WAIT, followed by a stray `mem_resp_valid` -> state IDLE, `mem_req_valid` = 0, `out_valid` = 0; the next lw completes normally.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding load/store unit between EX and WB
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_*               instruction from EX (valid/ready); lsu_opt, funct3, ALU address, store data
//   mem_req_*          memory request (valid/ready): word address, write enable, lane data, strobes
//   mem_resp_*         memory response pulse: read word and bus error
//   out_*              result to WB (valid/ready): data, register write enable, misalign, error
module riscv_lsu #(
    parameter int DATA_WIDTH    = 32,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int LSU_OPT_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LSU_OPT_WIDTH-1:0] in_lsu_opt,
    input  logic [2:0]               in_funct3,
    input  logic [DATA_WIDTH-1:0]    in_addr,
    input  logic [DATA_WIDTH-1:0]    in_wdata,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [DATA_WIDTH-1:0]    mem_req_addr,
    output logic [DATA_WIDTH-1:0]    mem_req_wdata,
    output logic [STRB_WIDTH-1:0]    mem_req_wstrb,
    input  logic                     mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]    mem_resp_rdata,
    input  logic                     mem_resp_err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_wen,
    output logic                     out_misalign,
    output logic                     out_err
);
    localparam logic [LSU_OPT_WIDTH-1:0] LSU_OPT_NONE  = 'd0;
    localparam logic [LSU_OPT_WIDTH-1:0] LSU_OPT_LOAD  = 'd1;
    localparam logic [LSU_OPT_WIDTH-1:0] LSU_OPT_STORE = 'd2;
    localparam logic [LSU_OPT_WIDTH-1:0] LSU_OPT_SYS   = 'd3;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_nx;

    logic [LSU_OPT_WIDTH-1:0] opt_q;
    logic [2:0]               f3_q;
    logic [DATA_WIDTH-1:0]    addr_q, wdata_q, res_data;
    logic                     res_wen, res_mis, res_err;

    logic ld_ok, st_ok, f3_bad, mis, go_mem, sx;
    logic [7:0]               ld_byte;
    logic [15:0]              ld_half;
    logic [DATA_WIDTH-1:0]    ld_data, st_wdata;
    logic [STRB_WIDTH-1:0]    st_wstrb;

    // Decode of the incoming instruction; misalignment is only judged for legal sizes
    assign ld_ok  = in_lsu_opt == LSU_OPT_LOAD  && in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign st_ok  = in_lsu_opt == LSU_OPT_STORE && in_funct3 inside {3'b000, 3'b001, 3'b010};
    assign f3_bad = (in_lsu_opt == LSU_OPT_LOAD && !ld_ok) || (in_lsu_opt == LSU_OPT_STORE && !st_ok);
    assign mis    = (ld_ok || st_ok) &&
                    ((in_funct3[1:0] == 2'b01 && in_addr[0]) || (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00));
    assign go_mem = (ld_ok || st_ok) && !mis;

    // funct3[2] selects zero extension for lbu/lhu
    assign sx      = !f3_q[2];
    assign ld_byte = mem_resp_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = addr_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    assign ld_data = f3_q[1:0] == 2'b00 ? {{(DATA_WIDTH-8){sx & ld_byte[7]}}, ld_byte} :
                     f3_q[1:0] == 2'b01 ? {{(DATA_WIDTH-16){sx & ld_half[15]}}, ld_half} : mem_resp_rdata;

    assign st_wdata = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                      f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    assign st_wstrb = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                      f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    assign in_ready      = state == IDLE;
    assign mem_req_valid = state == REQ;
    assign mem_req_we    = mem_req_valid && opt_q == LSU_OPT_STORE;
    assign mem_req_addr  = mem_req_valid ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    assign mem_req_wdata = mem_req_we ? st_wdata : '0;
    assign mem_req_wstrb = mem_req_we ? st_wstrb : '0;
    assign out_valid     = state == DONE;
    assign out_data      = res_data;
    assign out_wen       = res_wen;
    assign out_misalign  = res_mis;
    assign out_err       = res_err;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? (go_mem ? REQ : DONE) : IDLE;
            REQ:     state_nx = mem_req_ready ? WAIT : REQ;
            WAIT:    state_nx = mem_resp_valid ? DONE : WAIT;
            default: state_nx = out_ready ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            opt_q    <= '0;
            f3_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            res_data <= '0;
            res_wen  <= 1'b0;
            res_mis  <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                opt_q    <= in_lsu_opt;
                f3_q     <= in_funct3;
                addr_q   <= in_addr;
                wdata_q  <= in_wdata;
                // Pass-through result; memory ops overwrite it when the response lands
                res_data <= (in_lsu_opt == LSU_OPT_NONE || in_lsu_opt == LSU_OPT_SYS) ? in_addr : '0;
                res_wen  <= in_lsu_opt == LSU_OPT_NONE;
                res_mis  <= mis;
                res_err  <= f3_bad;
            end
            if (state == WAIT && mem_resp_valid) begin
                res_data <= (mem_resp_err || opt_q != LSU_OPT_LOAD) ? '0 : ld_data;
                res_wen  <= !mem_resp_err && opt_q == LSU_OPT_LOAD;
                res_mis  <= 1'b0;
                res_err  <= mem_resp_err;
            end
        end
    end
endmodule
